// File: rtl/frame_scan_ctrl_pkg.sv
// Shared types and constants for the path tracer frame sequencer.
// Stage latencies sum to the default datapath depth.
package frame_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } scan_state_e;

   localparam int H_RES_DEFAULT = 800;
   localparam int V_RES_DEFAULT = 600;

   localparam int RAYGEN_LAT = 3;
   localparam int INVDIR_LAT = 3;
   localparam int ISECT_LAT = 2;
   localparam int PATH_TRACER_LAT = RAYGEN_LAT + INVDIR_LAT + ISECT_LAT;

   localparam int ADDR_W_DEFAULT = 19;
   localparam int CNT_W_DEFAULT = 16;
   localparam int PIX_W = 10;

endpackage

// File: rtl/frame_scan_ctrl_if.sv
// Framebuffer write port: valid/ready handshake with address and hit bit.
// The sequencer is the master, the framebuffer the slave.
interface frame_scan_ctrl_if
   import frame_scan_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
);

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );

endinterface

// File: rtl/frame_scan_ctrl_raster_counter.sv
// Raster x/y walker with clear, enable and a last-pixel flag.
// Stops advancing is left to the caller via en.
module frame_scan_ctrl_raster_counter
   import frame_scan_ctrl_pkg::*;
#(
   parameter int H_RES = H_RES_DEFAULT,
   parameter int V_RES = V_RES_DEFAULT
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [PIX_W-1:0] x,
   output logic [PIX_W-1:0] y,
   output logic             last_pixel
);

   localparam logic [PIX_W-1:0] X_MAX = PIX_W'(H_RES - 1);
   localparam logic [PIX_W-1:0] Y_MAX = PIX_W'(V_RES - 1);

   logic [PIX_W-1:0] x_q, x_d;
   logic [PIX_W-1:0] y_q, y_d;
   logic             x_wrap;

   assign x_wrap     = (x_q == X_MAX);
   assign last_pixel = x_wrap & (y_q == Y_MAX);
   assign x          = x_q;
   assign y          = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (en) begin
         if (x_wrap) begin
            x_d = '0;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Frame sequencer: walks the raster into the tracer pipe, tracks
// in-flight pixels and streams hit bits to the framebuffer.
module frame_scan_ctrl
   import frame_scan_ctrl_pkg::*;
#(
   parameter int H_RES    = H_RES_DEFAULT,
   parameter int V_RES    = V_RES_DEFAULT,
   parameter int PIPE_LAT = PATH_TRACER_LAT,
   parameter int ADDR_W   = ADDR_W_DEFAULT,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic               sysclk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [PIX_W-1:0]   pixel_x,
   output logic [PIX_W-1:0]   pixel_y,
   output logic               pipe_stall,
   input  logic               hit_in,
   frame_scan_ctrl_if.master  wr,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   frame_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   scan_state_e         state_q, state_d;
   logic [PIPE_LAT-1:0] sr_q, sr_d;
   logic                wr_valid_q, wr_valid_d;
   logic                wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]    fc_q, fc_d;

   logic clr;
   logic issue;
   logic accept;
   logic last_pixel;

   assign pipe_stall  = wr_valid_q & ~wr.wr_ready;
   assign issue       = (state_q == SCAN) & ~pipe_stall;
   assign accept      = wr_valid_q & wr.wr_ready;
   assign busy        = (state_q == SCAN) | (state_q == DRAIN);
   assign done        = (state_q == DONE);
   assign frame_count = fc_q;
   assign wr.wr_valid = wr_valid_q;
   assign wr.wr_data  = wr_data_q;
   assign wr.wr_addr  = wr_addr_q;

   frame_scan_ctrl_raster_counter #(
      .H_RES(H_RES),
      .V_RES(V_RES)
   ) u_raster_counter (
      .sysclk     (sysclk),
      .rst        (rst),
      .clr        (clr),
      .en         (issue & ~last_pixel),
      .x          (pixel_x),
      .y          (pixel_y),
      .last_pixel (last_pixel)
   );

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      wr_valid_d = wr_valid_q;
      wr_data_d  = wr_data_q;
      wr_addr_d  = wr_addr_q;
      fc_d       = fc_q;
      clr        = 1'b0;

      // Output register loads exactly when the pipe advances.
      if (!pipe_stall) begin
         sr_d       = (sr_q << 1) | PIPE_LAT'(issue);
         wr_valid_d = sr_q[PIPE_LAT-1];
         if (sr_q[PIPE_LAT-1]) wr_data_d = hit_in;
      end
      if (accept) wr_addr_d = wr_addr_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d   = SCAN;
               clr       = 1'b1;
               wr_addr_d = '0;
            end
         end
         SCAN: begin
            if (issue && last_pixel) state_d = DRAIN;
         end
         DRAIN: begin
            if (accept && wr_addr_q == LAST_ADDR) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            fc_d    = fc_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (abort && state_q != IDLE) begin
         state_d    = IDLE;
         sr_d       = '0;
         wr_valid_d = 1'b0;
         fc_d       = fc_q;
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= 1'b0;
         wr_addr_q  <= '0;
         fc_q       <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         wr_valid_q <= wr_valid_d;
         wr_data_q  <= wr_data_d;
         wr_addr_q  <= wr_addr_d;
         fc_q       <= fc_d;
      end
   end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed bench for frame_scan_ctrl on a 4x3 raster, 3-deep pipe.
// The datapath is modelled as a stallable delay line returning x[0].
module tb_frame_scan_ctrl;

   localparam int H    = 4;
   localparam int V    = 3;
   localparam int LAT  = 3;
   localparam int AW   = 4;
   localparam int CW   = 16;
   localparam int NPIX = H * V;

   logic          sysclk = 1'b0;
   logic          rst    = 1'b1;
   logic          start  = 1'b0;
   logic          abort  = 1'b0;
   logic          hit_in;
   logic [9:0]    pixel_x;
   logic [9:0]    pixel_y;
   logic          pipe_stall;
   logic          busy;
   logic          done;
   logic [CW-1:0] frame_count;

   frame_scan_ctrl_if #(.ADDR_W(AW)) wif ();

   frame_scan_ctrl #(
      .H_RES(H), .V_RES(V), .PIPE_LAT(LAT), .ADDR_W(AW), .CNT_W(CW)
   ) dut (
      .sysclk      (sysclk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .pipe_stall  (pipe_stall),
      .hit_in      (hit_in),
      .wr          (wif),
      .busy        (busy),
      .done        (done),
      .frame_count (frame_count)
   );

   always #5 sysclk = ~sysclk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0;
   int stall_cnt = 0;
   int wr_total = 0;
   int saved = 0;

   logic [AW-1:0] wa[$];
   logic          wd[$];
   int            wc[$];
   logic [19:0]   pq[$];
   int            ic[$];

   bit [LAT-1:0] dp = '0;
   bit           s_stall = 1'b0;
   bit           s_x0 = 1'b0;

   assign hit_in = dp[LAT-1];

   always @(negedge sysclk) begin
      s_stall = pipe_stall;
      s_x0    = pixel_x[0];
   end

   always @(posedge sysclk) begin
      if (!s_stall) dp <= {dp[LAT-2:0], s_x0};
   end

   always @(negedge sysclk) begin
      cyc = cyc + 1;
      if (wif.wr_valid && wif.wr_ready) begin
         wa.push_back(wif.wr_addr);
         wd.push_back(wif.wr_data);
         wc.push_back(cyc);
         wr_total = wr_total + 1;
      end
      if (done) done_cnt = done_cnt + 1;
      if (pipe_stall) stall_cnt = stall_cnt + 1;
      if (busy && (pq.size() == 0 || {pixel_y, pixel_x} != pq[pq.size()-1])) begin
         pq.push_back({pixel_y, pixel_x});
         ic.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_logs();
      @(posedge sysclk);
      #1;
      wa.delete();
      wd.delete();
      wc.delete();
      pq.delete();
      ic.delete();
      stall_cnt = 0;
   endtask

   task automatic pulse_start();
      @(posedge sysclk);
      #2 start = 1'b1;
      @(posedge sysclk);
      #2 start = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int n = 0;
      while (done_cnt == prev && n < 200) begin
         @(posedge sysclk);
         n++;
      end
      chk("done_seen", done_cnt, prev + 1);
   endtask

   task automatic wait_writes(input int n);
      int k = 0;
      while (wa.size() < n && k < 200) begin
         @(posedge sysclk);
         k++;
      end
      chk("wr_reach", 32'(wa.size() >= n), 1);
      #2;
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_count"}, 32'(wa.size()), NPIX);
      for (int i = 0; i < wa.size() && i < NPIX; i++) begin
         chk({tag, "_addr"}, 32'(wa[i]), i);
         chk({tag, "_data"}, 32'(wd[i]), i & 1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wif.wr_ready = 1'b1;
      #12;
      chk("rst_ctl", {busy, done, wif.wr_valid, pipe_stall, wif.wr_data}, 0);
      chk("rst_pix", {pixel_y, pixel_x}, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_addr", wif.wr_addr, 0);
      @(negedge sysclk) rst = 1'b0;

      // Basic frame and raster ordering
      clr_logs();
      pulse_start();
      wait_done(0);
      @(negedge sysclk);
      chk("f1_busy", busy, 0);
      chk("f1_done_low", done, 0);
      chk("f1_fc", frame_count, 1);
      check_frame("f1");
      chk("f1_lat", wc[0] - ic[0], 4);
      chk("f1_b2b", wc[NPIX-1] - wc[0], NPIX - 1);
      chk("issue_cnt", 32'(pq.size()), NPIX);
      chk("wrap_3_0", 32'(pq[3]), {10'd0, 10'd3});
      chk("wrap_0_1", 32'(pq[4]), {10'd1, 10'd0});
      chk("last_issue", 32'(pq[NPIX-1]), {10'd2, 10'd3});

      // Backpressure for five cycles
      clr_logs();
      pulse_start();
      wait_writes(3);
      wif.wr_ready = 1'b0;
      repeat (5) begin
         @(negedge sysclk);
         chk("bp_stall", pipe_stall, 1);
         chk("bp_pix", {pixel_y, pixel_x}, {10'd1, 10'd3});
      end
      @(posedge sysclk);
      #2 wif.wr_ready = 1'b1;
      wait_done(1);
      @(negedge sysclk);
      chk("f2_fc", frame_count, 2);
      chk("f2_stalls", stall_cnt, 5);
      check_frame("f2");
      chk("f2_span", wc[NPIX-1] - wc[0], NPIX - 1 + 5);

      // Start while busy is ignored
      clr_logs();
      pulse_start();
      repeat (3) @(posedge sysclk);
      #2 start = 1'b1;
      @(posedge sysclk);
      #2 start = 1'b0;
      wait_done(2);
      repeat (30) @(posedge sysclk);
      check_frame("f3");
      chk("f3_dones", done_cnt, 3);
      @(negedge sysclk);
      chk("f3_busy", busy, 0);
      chk("f3_fc", frame_count, 3);

      // Abort mid-frame
      clr_logs();
      pulse_start();
      wait_writes(6);
      abort = 1'b1;
      @(posedge sysclk);
      #2 abort = 1'b0;
      @(negedge sysclk);
      chk("ab_busy", busy, 0);
      chk("ab_valid", wif.wr_valid, 0);
      repeat (20) @(posedge sysclk);
      chk("ab_writes", 32'(wa.size()), 7);
      chk("ab_dones", done_cnt, 3);
      @(negedge sysclk);
      chk("ab_fc", frame_count, 3);

      clr_logs();
      pulse_start();
      wait_done(3);
      @(negedge sysclk);
      chk("f5_fc", frame_count, 4);
      check_frame("f5");

      // Asynchronous reset during drain
      clr_logs();
      pulse_start();
      wait_writes(10);
      #1 rst = 1'b1;
      #1;
      chk("ar_ctl", {busy, done, wif.wr_valid, pipe_stall, wif.wr_data}, 0);
      chk("ar_pix", {pixel_y, pixel_x}, 0);
      chk("ar_fc", frame_count, 0);
      chk("ar_addr", wif.wr_addr, 0);
      saved = wr_total;
      @(posedge sysclk);
      @(negedge sysclk) rst = 1'b0;
      repeat (20) @(posedge sysclk);
      chk("ar_quiet", wr_total, saved);
      @(negedge sysclk);
      chk("ar_busy", busy, 0);

      clr_logs();
      pulse_start();
      wait_done(done_cnt);
      @(negedge sysclk);
      chk("f6_fc", frame_count, 1);
      check_frame("f6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
